// File: rtl/noc_port_arbiter.sv
// Round-robin, packet-locking arbiter for one router output port.
// Holds a grant until the granted requester's tail flit moves, then re-arbitrates without a bubble.
module noc_port_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int INDEX_WIDTH    = $clog2(NUM_REQUESTERS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQUESTERS-1:0] req_valid,
  input  logic [NUM_REQUESTERS-1:0] req_tail,
  input  logic                      out_ready,
  output logic [NUM_REQUESTERS-1:0] grant_oh,
  output logic [INDEX_WIDTH-1:0]    grant_idx,
  output logic                      grant_valid,
  output logic                      xfer,
  output logic                      xfer_tail
);

  logic [INDEX_WIDTH-1:0]    prio;
  logic [INDEX_WIDTH-1:0]    prio_after;
  logic [INDEX_WIDTH-1:0]    search_prio;
  logic [INDEX_WIDTH-1:0]    win_idx;
  logic [NUM_REQUESTERS-1:0] candidates;
  logic [NUM_REQUESTERS-1:0] win_oh;
  logic                      locked;
  logic                      win_found;
  int                        prio_sum;
  int                        cand_pos;

  assign locked = |grant_oh;

  // Only the granted port's valid/tail reach the transfer path, since grant_oh is one-hot.
  assign xfer      = locked & (|(req_valid & grant_oh)) & out_ready;
  assign xfer_tail = xfer & (|(req_tail & grant_oh));

  always_comb begin
    prio_sum = int'(grant_idx) + 1;
    if (prio_sum >= NUM_REQUESTERS) prio_sum = 0;
    prio_after = INDEX_WIDTH'(prio_sum);
  end

  assign search_prio = locked ? prio_after : prio;
  assign candidates  = locked ? (req_valid & ~grant_oh) : req_valid;

  // Scan from search_prio upward, wrapping modulo NUM_REQUESTERS.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_oh    = '0;
    cand_pos  = 0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      cand_pos = int'(search_prio) + k;
      if (cand_pos >= NUM_REQUESTERS) cand_pos = cand_pos - NUM_REQUESTERS;
      if (!win_found && ((candidates & (NUM_REQUESTERS'(1) << cand_pos)) != '0)) begin
        win_found = 1'b1;
        win_idx   = INDEX_WIDTH'(cand_pos);
        win_oh    = NUM_REQUESTERS'(1) << cand_pos;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_oh    <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      prio        <= '0;
    end else if (!locked) begin
      if (win_found) begin
        grant_oh    <= win_oh;
        grant_idx   <= win_idx;
        grant_valid <= 1'b1;
      end
    end else if (xfer_tail) begin
      prio        <= prio_after;
      grant_oh    <= win_oh;
      grant_idx   <= win_idx;
      grant_valid <= win_found;
    end
  end

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Scoreboard bench for noc_port_arbiter: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_noc_port_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req_valid;
  logic [3:0] req_tail;
  logic       out_ready;
  logic [3:0] grant_oh;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       xfer;
  logic       xfer_tail;

  typedef struct {
    logic [3:0] oh;
    logic [1:0] idx;
    logic       gv;
    logic       x;
    logic       xt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  noc_port_arbiter #(.NUM_REQUESTERS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_tail   (req_tail),
    .out_ready  (out_ready),
    .grant_oh   (grant_oh),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid),
    .xfer       (xfer),
    .xfer_tail  (xfer_tail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the edge and queue what the outputs must show that cycle.
  task automatic applyStimulus(input logic rst, input logic [3:0] v, input logic [3:0] t,
                               input logic rdy, input logic [3:0] e_oh, input logic [1:0] e_idx,
                               input logic e_x, input logic e_xt);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rst;
    req_valid = v;
    req_tail  = t;
    out_ready = rdy;
    e.oh  = e_oh;
    e.idx = e_idx;
    e.gv  = (e_oh != 4'b0000);
    e.x   = e_x;
    e.xt  = e_xt;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    total++;
    if (grant_oh !== e.oh) begin
      bad++;
      $display("[TB] FAIL grant_oh at %0t: got %b want %b", $time, grant_oh, e.oh);
    end
    total++;
    if (grant_idx !== e.idx) begin
      bad++;
      $display("[TB] FAIL grant_idx at %0t: got %0d want %0d", $time, grant_idx, e.idx);
    end
    total++;
    if (grant_valid !== e.gv) begin
      bad++;
      $display("[TB] FAIL grant_valid at %0t: got %b want %b", $time, grant_valid, e.gv);
    end
    total++;
    if (xfer !== e.x) begin
      bad++;
      $display("[TB] FAIL xfer at %0t: got %b want %b", $time, xfer, e.x);
    end
    total++;
    if (xfer_tail !== e.xt) begin
      bad++;
      $display("[TB] FAIL xfer_tail at %0t: got %b want %b", $time, xfer_tail, e.xt);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) checkOutput(exp_q.pop_front());
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    req_valid = 4'b0000;
    req_tail  = 4'b0000;
    out_ready = 1'b0;

    // Reset then idle
    repeat (3) applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
    repeat (5) applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Single-flit fairness: 0,1,2,3,0,1,2
    applyStimulus(1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1);
    applyStimulus(1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1);
    applyStimulus(1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1);
    applyStimulus(1'b0, 4'b1111, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1);
    applyStimulus(1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1);
    applyStimulus(1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1);
    applyStimulus(1'b0, 4'b0100, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Packet lock: port 1 sends 4 flits while port 2 waits (prio is 3 here)
    applyStimulus(1'b0, 4'b0110, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0110, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'b0110, 4'b0100, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'b0110, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'b0110, 4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1);
    applyStimulus(1'b0, 4'b0100, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1);

    // Backpressure then stall on port 3; port 0 must not leak through
    applyStimulus(1'b0, 4'b1000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b1000, 4'b0000, 1'b0, 4'b1000, 2'd3, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b1000, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b1000, 4'b0000, 1'b0, 4'b1000, 2'd3, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0001, 4'b0001, 1'b1, 4'b1000, 2'd3, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0001, 4'b0001, 1'b1, 4'b1000, 2'd3, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b1001, 4'b0000, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'b1001, 4'b1000, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1);
    applyStimulus(1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1);

    // Solo requester 0: one transfer every two cycles
    applyStimulus(1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1);
    applyStimulus(1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1);

    // Port 1 drops valid mid-packet, then finishes; leaves prio at 2
    applyStimulus(1'b0, 4'b0010, 4'b0010, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0010, 4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1);

    // Reset mid-packet on port 2, then prio restarts at 0
    applyStimulus(1'b0, 4'b0100, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0100, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0110, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0110, 4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1);
    applyStimulus(1'b0, 4'b0100, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
